load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 512, the number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1, CPU access request.
REQ-005 SHALL have port req_write, input, 1, 1=store, 0=load.
REQ-006 SHALL have port req_size, input, 2, access size: 0=byte, 1=half, 2=word, 3=reserved (treated as fault).
REQ-007 SHALL have port req_signed, input, 1, sign-extend sub-word loads; ignored for words and stores.
REQ-008 SHALL have port req_addr, input, 32, CPU byte address.
REQ-009 SHALL have port req_wdata, input, 32, store data, right-justified for byte and half.
REQ-010 SHALL have port busy, output, 1, request not accepted this cycle; CPU stall.
REQ-011 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 32, extended load result; 0 for stores and faults.
REQ-013 SHALL have port fault, output, 1, qualified by resp_valid: misaligned, reserved size, or out-of-range access.
REQ-014 SHALL have port mem_addr, output, 32, word-aligned memory address {addr[31:2],2'b00}.
REQ-015 SHALL have port mem_read, output, 1, memory read strobe.
REQ-016 SHALL have port mem_write, output, 1, memory write strobe, full 32-bit word.
REQ-017 SHALL have port mem_wdata, output, 32, word to write.
REQ-018 SHALL have port mem_rdata, input, 32, read data, valid the cycle after mem_read is high.

Function
REQ-019 SHALL use FSM states IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_WAIT, RMW_WR, RESP.
REQ-020 SHALL accept a request only when req_valid=1 and state=IDLE; accepted request fields are latched, and later input changes have no effect.
REQ-021 SHALL drive busy=1 in every state except IDLE and RESP.
REQ-022 SHALL flag a fault when: half with addr[0]=1; word with addr[1:0]!=0; req_size=3; or addr[31:2] >= MEM_WORDS. A faulted request goes IDLE->RESP and asserts no memory strobes.
REQ-023 SHALL sequence a load as IDLE->RD (mem_read=1)->RD_WAIT (sample mem_rdata)->RESP, giving resp_valid 3 cycles after acceptance.
REQ-024 SHALL sequence a word store as IDLE->WR (mem_write=1, mem_wdata=req_wdata)->RESP, giving resp_valid 2 cycles after acceptance.
REQ-025 SHALL sequence a byte/half store as IDLE->RMW_RD->RMW_WAIT (merge)->RMW_WR->RESP, giving resp_valid 4 cycles after acceptance; only the addressed lanes change.
REQ-026 SHALL use little-endian lanes: byte k = bits 8k+7:8k; half at addr[1]=h = bits 16h+15:16h.
REQ-027 SHALL zero-extend sub-word loads when req_signed=0 and sign-extend them when req_signed=1.
REQ-028 SHALL assert resp_valid for exactly one cycle, in RESP, with resp_rdata and fault stable in that cycle; RESP returns to IDLE.
REQ-029 SHALL drive mem_read and mem_write high only in the states named above, never both in one cycle, and at most one strobe per state visit.
REQ-030 SHALL hold mem_addr constant from the first strobe cycle until RESP.
REQ-031 SHALL allow back-to-back operation: a new request presented in the RESP cycle is accepted on the next edge only if the state is IDLE, i.e. one idle cycle separates transactions.

Reset
REQ-032 SHALL, on rst=1 at a rising edge, force state=IDLE and clear busy, resp_valid, resp_rdata, fault, mem_read, mem_write, mem_addr and mem_wdata to 0.
REQ-033 SHALL abort any in-flight transaction on reset with no mem_write in the cycle following the reset edge, and produce no resp_valid for it.
REQ-034 SHALL give rst priority over a simultaneous req_valid; that request is not accepted.

Verification
REQ-035 Memory word 0x10=0x8899AABB; lb signed at addr 0x12 -> resp_rdata=0xFFFFFF99 at cycle T+3, fault=0; lbu at the same address -> 0x00000099.
REQ-036 sh 0x1234 at addr 0x22 over word 0xDEADBEEF -> mem_write at T+3 with mem_wdata=0x1234BEEF, resp_valid at T+4.
REQ-037 lw at addr 0x06 -> resp_valid at T+1, fault=1, resp_rdata=0, no mem_read or mem_write; lw at addr 0x800 with MEM_WORDS=512 -> fault=1.
REQ-038 sw 0xCAFEF00D at addr 0x40 followed by lw at 0x40 -> mem_write at T+1, resp at T+2, load returns 0xCAFEF00D; busy=1 exactly in non-IDLE/RESP cycles.
REQ-039 rst=1 during RMW_WAIT of sb -> next cycle state IDLE, all outputs 0, memory word unchanged.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte, half and word CPU accesses into word-wide memory
// cycles. Sub-word stores use read-modify-write so only the addressed lanes change.
module load_store_unit #(
  parameter int MEM_WORDS = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        fault,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_WAIT, RMW_WR, RESP
  } state_t;

  localparam logic [31:0] WORD_LIMIT = 32'(MEM_WORDS);

  state_t      state;
  logic [1:0]  lat_size;
  logic [1:0]  lat_off;
  logic        lat_signed;
  logic [15:0] lat_wdata;
  logic        req_fault;

  // Misalignment, the reserved size and out-of-range words all fault.
  always_comb begin
    req_fault = 1'b0;
    case (req_size)
      2'd1:    req_fault = req_addr[0];
      2'd2:    req_fault = (req_addr[1:0] != 2'b00);
      2'd3:    req_fault = 1'b1;
      default: req_fault = 1'b0;
    endcase
    if ({2'b00, req_addr[31:2]} >= WORD_LIMIT) req_fault = 1'b1;
  end

  function automatic logic [31:0] extract_load(
    input logic [31:0] word,
    input logic [1:0]  sz,
    input logic [1:0]  off,
    input logic        sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (sz)
      2'd0:    r = sgn ? {{24{b[7]}}, b} : {24'h0, b};
      2'd1:    r = sgn ? {{16{h[15]}}, h} : {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(
    input logic [31:0] old,
    input logic [15:0] wd,
    input logic [1:0]  sz,
    input logic [1:0]  off
  );
    logic [31:0] r;
    r = old;
    if (sz == 2'd0) r[{off, 3'b000} +: 8] = wd[7:0];
    else            r[{off[1], 4'b0000} +: 16] = wd;
    return r;
  endfunction

  // All outputs are registered: each transition sets the outputs of the state
  // it enters, and strobes/response flags default low so they pulse once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      fault      <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      lat_size   <= 2'd0;
      lat_off    <= 2'd0;
      lat_signed <= 1'b0;
      lat_wdata  <= 16'h0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      fault      <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_size   <= req_size;
            lat_off    <= req_addr[1:0];
            lat_signed <= req_signed;
            lat_wdata  <= req_wdata[15:0];
            mem_addr   <= {req_addr[31:2], 2'b00};
            if (req_fault) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              fault      <= 1'b1;
              busy       <= 1'b0;
            end else if (!req_write) begin
              state    <= RD;
              mem_read <= 1'b1;
              busy     <= 1'b1;
            end else if (req_size == 2'd2) begin
              state     <= WR;
              mem_write <= 1'b1;
              mem_wdata <= req_wdata;
              busy      <= 1'b1;
            end else begin
              state    <= RMW_RD;
              mem_read <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        RD: state <= RD_WAIT;
        RD_WAIT: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= extract_load(mem_rdata, lat_size, lat_off, lat_signed);
          busy       <= 1'b0;
        end
        WR: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          busy       <= 1'b0;
        end
        RMW_RD: state <= RMW_WAIT;
        RMW_WAIT: begin
          state     <= RMW_WR;
          mem_write <= 1'b1;
          mem_wdata <= merge_store(mem_rdata, lat_wdata, lat_size, lat_off);
        end
        RMW_WR: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          busy       <= 1'b0;
        end
        RESP: state <= IDLE;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: attached word RAM, a transaction-level
// reference model, directed literal checks and randomized traffic.
module tb_load_store_unit;

  localparam int MEM_WORDS = 512;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        fault;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  int tests = 0;
  int failures = 0;
  int cyc = 0;
  bit rst_last = 1'b1;

  bit          pend = 1'b0;
  int          t_acc = 0;
  int          lat = 0;
  int          rd_cyc = -1;
  int          wr_cyc = -1;
  bit          exp_fault = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  logic [31:0] exp_wdata = 32'h0;
  logic [31:0] exp_maddr = 32'h0;

  logic [31:0] last_rdata = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  bit          last_fault = 1'b0;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .fault      (fault),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous RAM: read data appears the cycle after mem_read.
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr[10:2]] <= mem_wdata;
    if (mem_read)  mem_rdata <= ram[mem_addr[10:2]];
  end

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_last <= rst;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: what one access must return and leave in memory, from lane arithmetic.
  task automatic modelRequest(
    input  bit          wr,
    input  logic [1:0]  sz,
    input  bit          sg,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output bit          flt,
    output logic [31:0] rdata,
    output logic [31:0] newword,
    output int          latency
  );
    int unsigned widx, off, nbytes, shift;
    logic [31:0] mask, old, v;
    widx   = addr / 4;
    off    = addr % 4;
    nbytes = 1 << sz;
    flt = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) ||
          (sz == 2'd2 && off != 0) || (widx >= MEM_WORDS);
    rdata   = 32'h0;
    newword = 32'h0;
    latency = 1;
    if (!flt) begin
      old   = ref_mem[widx];
      shift = 8 * off;
      mask  = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      if (!wr) begin
        v = (old >> shift) & mask;
        if (sg && nbytes < 4 && ((v >> (8 * nbytes - 1)) & 32'd1) == 32'd1) v = v | ~mask;
        rdata   = v;
        newword = old;
        latency = 3;
      end else begin
        newword = (old & ~(mask << shift)) | ((wd & mask) << shift);
        latency = (nbytes == 4) ? 2 : 4;
      end
    end
  endtask

  task automatic startRequest(input bit wr, input logic [1:0] sz, input bit sg,
                              input logic [31:0] addr, input logic [31:0] wd);
    bit          flt;
    logic [31:0] rd, nw;
    int          l;
    modelRequest(wr, sz, sg, addr, wd, flt, rd, nw, l);
    last_rdata = 32'hA5A5_5A5A;
    last_wdata = 32'h5A5A_A5A5;
    last_fault = 1'b0;
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    t_acc      = cyc;
    lat        = l;
    exp_fault  = flt;
    exp_rdata  = rd;
    exp_wdata  = nw;
    exp_maddr  = {addr[31:2], 2'b00};
    rd_cyc     = (!flt && (!wr || sz != 2'd2)) ? cyc + 1 : -1;
    wr_cyc     = (!flt && wr) ? ((sz == 2'd2) ? cyc + 1 : cyc + 3) : -1;
    pend       = 1'b1;
  endtask

  // One full transaction; request inputs get garbage while the unit is busy
  // and in RESP, and the next request may follow in the very next idle cycle.
  task automatic applyStimulus(input bit wr, input logic [1:0] sz, input bit sg,
                               input logic [31:0] addr, input logic [31:0] wd);
    startRequest(wr, sz, sg, addr, wd);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      req_valid  = 1'($urandom_range(0, 1));
      req_write  = 1'($urandom_range(0, 1));
      req_size   = 2'($urandom_range(0, 3));
      req_signed = 1'($urandom_range(0, 1));
      req_addr   = $urandom;
      req_wdata  = $urandom;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (wr && !exp_fault) ref_mem[addr[10:2]] = exp_wdata;
  endtask

  task automatic applyAbort(input logic [31:0] addr, input logic [7:0] wd);
    startRequest(1'b1, 2'd0, 1'b0, addr, {24'h0, wd});
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    pend = 1'b0;
    rst  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic applyResetCollision();
    pend       = 1'b0;
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_size   = 2'd2;
    req_addr   = 32'h40;
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  initial begin
    bit exp_rv;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        if (rst_last) begin
          checkOutput("reset_flags", {27'h0, busy, resp_valid, fault, mem_read, mem_write}, 32'h0);
          checkOutput("reset_rdata", resp_rdata, 32'h0);
          checkOutput("reset_mem_addr", mem_addr, 32'h0);
          checkOutput("reset_mem_wdata", mem_wdata, 32'h0);
        end else begin
          exp_rv = pend && (cyc == t_acc + lat);
          checkOutput("resp_valid", {31'h0, resp_valid}, {31'h0, exp_rv});
          checkOutput("busy", {31'h0, busy}, {31'h0, pend && cyc > t_acc && cyc < t_acc + lat});
          checkOutput("mem_read", {31'h0, mem_read}, {31'h0, pend && cyc == rd_cyc});
          checkOutput("mem_write", {31'h0, mem_write}, {31'h0, pend && cyc == wr_cyc});
          if (exp_rv) begin
            checkOutput("fault", {31'h0, fault}, {31'h0, exp_fault});
            checkOutput("resp_rdata", resp_rdata, exp_fault ? 32'h0 : exp_rdata);
            last_rdata = resp_rdata;
            last_fault = fault;
          end
          if (pend && !exp_fault && cyc > t_acc && cyc <= t_acc + lat)
            checkOutput("mem_addr", mem_addr, exp_maddr);
          if (pend && cyc == wr_cyc) begin
            checkOutput("mem_wdata", mem_wdata, exp_wdata);
            last_wdata = mem_wdata;
          end
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      ref_mem[i] = $urandom;
      ram[i]     = ref_mem[i];
    end
    ref_mem[4] = 32'h8899AABB;
    ram[4]     = 32'h8899AABB;
    ref_mem[8] = 32'hDEADBEEF;
    ram[8]     = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(1'b0, 2'd0, 1'b1, 32'h12, 32'h0);
    checkOutput("model_lb", exp_rdata, 32'hFFFFFF99);
    checkOutput("lb_signed", last_rdata, 32'hFFFFFF99);
    checkOutput("lb_fault", {31'h0, last_fault}, 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h12, 32'h0);
    checkOutput("lbu", last_rdata, 32'h00000099);

    applyStimulus(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234);
    checkOutput("model_sh", exp_wdata, 32'h1234BEEF);
    checkOutput("sh_mem_wdata", last_wdata, 32'h1234BEEF);
    applyStimulus(1'b0, 2'd1, 1'b1, 32'h20, 32'h0);
    checkOutput("lh_signed", last_rdata, 32'hFFFFBEEF);
    applyStimulus(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
    checkOutput("lh_upper", last_rdata, 32'h00001234);

    applyStimulus(1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
    checkOutput("lw_misaligned_fault", {31'h0, last_fault}, 32'h1);
    checkOutput("lw_misaligned_rdata", last_rdata, 32'h0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h800, 32'h0);
    checkOutput("lw_range_fault", {31'h0, last_fault}, 32'h1);

    applyStimulus(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D);
    checkOutput("sw_mem_wdata", last_wdata, 32'hCAFEF00D);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    checkOutput("lw_after_sw", last_rdata, 32'hCAFEF00D);

    applyAbort(32'h11, 8'h55);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    checkOutput("word_after_abort", last_rdata, 32'h8899AABB);

    applyResetCollision();

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
